// File: rtl/truth_table_scanner.sv
// truth_table_scanner: walks every input vector of a combinational function,
// captures its output into a truth table, then streams the indices of the
// set minterms over a valid/ready handshake and pulses done.
module truth_table_scanner #(
  parameter int N      = 4,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [N-1:0]      probe_a,
  input  logic              probe_z,
  output logic              busy,
  output logic              done,
  output logic [2**N-1:0]   table_out,
  output logic [N:0]        ones_count,
  output logic              mt_valid,
  output logic [N-1:0]      mt_index,
  input  logic              mt_ready
);

  localparam int DEPTH = 2**N;
  localparam logic [3:0]   SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [N-1:0] LAST_VEC    = N'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, FIN} state_t;

  state_t             state;
  logic [3:0]         settle_cnt;
  logic [DEPTH-1:0]   work;        // minterms still to be emitted
  logic [DEPTH-1:0]   table_cap;   // table including the sample taken this edge
  logic [DEPTH-1:0]   work_after;  // working copy once the current index is accepted
  logic [N-1:0]       cap_low;
  logic [N-1:0]       after_low;

  // Priority encoder: index of the lowest set bit (0 when none are set).
  function automatic logic [N-1:0] lowest_set(input logic [DEPTH-1:0] v);
    logic [N-1:0] r;
    r = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (v[i]) r = N'(i);
    end
    return r;
  endfunction

  // Look-ahead copies so the first and next minterm can be registered
  // on the same edge that produces them (no bubble in the stream).
  always_comb begin
    table_cap           = table_out;
    table_cap[probe_a]  = probe_z;
    work_after          = work;
    work_after[mt_index] = 1'b0;
  end

  assign cap_low   = lowest_set(table_cap);
  assign after_low = lowest_set(work_after);

  // Main controller: scan every vector, then stream minterms, then pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      probe_a    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      table_out  <= '0;
      ones_count <= '0;
      mt_valid   <= 1'b0;
      mt_index   <= '0;
      settle_cnt <= '0;
      work       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          probe_a <= '0;
          if (start) begin
            state      <= SCAN;
            busy       <= 1'b1;
            table_out  <= '0;
            ones_count <= '0;
            settle_cnt <= SETTLE_LAST;
          end
        end
        SCAN: begin
          if (settle_cnt == 4'd0) begin
            // The vector has been stable for SETTLE cycles: sample it.
            table_out[probe_a] <= probe_z;
            if (probe_z) ones_count <= ones_count + (N+1)'(1);
            if (probe_a != LAST_VEC) begin
              probe_a    <= probe_a + N'(1);
              settle_cnt <= SETTLE_LAST;
            end else begin
              probe_a  <= '0;
              state    <= EMIT;
              work     <= table_cap;
              mt_valid <= |table_cap;
              mt_index <= cap_low;
            end
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        EMIT: begin
          if (!mt_valid) begin
            // Nothing left to emit (or table was empty).
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (mt_ready) begin
            work     <= work_after;
            mt_valid <= |work_after;
            if (|work_after) mt_index <= after_low;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
